dram_window_fetch: RTL

- Read-side neighbour of the frame DRAM model. It sits directly downstream of the 8-bit, 19-bit-address, 1-cycle-read-latency image memory.
- On start it fetches one full frame in raster order and emits a 3x3 neighbourhood window for every pixel to the filter core, which is downstream.
- Pixels outside the image are zero-padded.
- Output uses a valid/ready handshake with full backpressure.

---
 rtl/dram_window_fetch.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dram_window_fetch.sv
// Streams one frame from the image DRAM in raster order and emits a zero-padded
// 3x3 neighbourhood per pixel on a valid/ready port with full backpressure.
module dram_window_fetch #(
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned A_WIDTH = 19,
  parameter int unsigned D_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 ren,
  output logic [A_WIDTH-1:0]   raddr,
  input  logic [D_WIDTH-1:0]   rdata,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [9*D_WIDTH-1:0] win_data,
  output logic                 win_last
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned XW   = $clog2(IMG_W);
  localparam int unsigned YW   = $clog2(IMG_H + 2);

  localparam logic [A_WIDTH-1:0] LastAddr = A_WIDTH'(NPIX - 1);
  localparam logic [XW-1:0]      XMax     = XW'(IMG_W - 1);
  localparam logic [YW-1:0]      YMax     = YW'(IMG_H - 1);
  localparam logic [YW-1:0]      YEnd     = YW'(IMG_H);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e               state_q;
  logic [A_WIDTH-1:0]   addr_q;
  logic                 rd_vld_q, skid_vld_q, skid_vld_d;
  logic [D_WIDTH-1:0]   skid_q;
  logic [XW-1:0]        px_q, cx_q;
  logic [YW-1:0]        py_q, cy_q;
  logic                 fin_q;
  logic [3*D_WIDTH-1:0] col0_q, col1_q, new_col;
  logic                 win_valid_q, win_last_q;
  logic [9*D_WIDTH-1:0] win_data_q, win_n;
  logic [D_WIDTH-1:0]   lb0 [IMG_W];
  logic [D_WIDTH-1:0]   lb1 [IMG_W];

  logic                 active, real_px, pix_avail, produce, advance, ren_c, is_last;
  logic [D_WIDTH-1:0]   pix, elem;

  // Input position px/py runs W+1 pixels ahead of the window centre cx/cy;
  // rows past the image are fed as zero pixels to flush the last windows.
  assign active    = (state_q == StRun) || (state_q == StDrain);
  assign real_px   = py_q < YEnd;
  assign pix_avail = active && !fin_q && (real_px ? (skid_vld_q || rd_vld_q) : 1'b1);
  assign pix       = !real_px ? '0 : (skid_vld_q ? skid_q : rdata);
  assign produce   = (py_q > YW'(1)) || ((py_q == YW'(1)) && (px_q != '0));
  assign advance   = pix_avail && (!produce || !win_valid_q || win_ready);
  assign is_last   = (cx_q == XMax) && (cy_q == YMax);

  // A read is only issued when the skid entry will be free to catch its data.
  assign skid_vld_d = skid_vld_q ? (!advance || rd_vld_q) : (rd_vld_q && !advance);
  assign ren_c      = (state_q == StRun) && !skid_vld_d;

  assign ren       = ren_c;
  assign raddr     = addr_q;
  assign busy      = active;
  assign done      = (state_q == StDone);
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_last  = win_last_q;

  always_comb begin
    new_col = {pix, lb0[px_q], lb1[px_q]};
    win_n   = '0;
    elem    = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (c == 0)      elem = col0_q[D_WIDTH*r +: D_WIDTH];
        else if (c == 1) elem = col1_q[D_WIDTH*r +: D_WIDTH];
        else             elem = new_col[D_WIDTH*r +: D_WIDTH];
        if ((c == 0 && cx_q == '0) || (c == 2 && cx_q == XMax) ||
            (r == 0 && cy_q == '0) || (r == 2 && cy_q == YMax)) begin
          elem = '0;
        end
        win_n[D_WIDTH*(3*r+c) +: D_WIDTH] = elem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      lb1[px_q] <= lb0[px_q];
      lb0[px_q] <= pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rd_vld_q    <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_q      <= '0;
      px_q        <= '0;
      py_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      fin_q       <= 1'b0;
      col0_q      <= '0;
      col1_q      <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            addr_q  <= '0;
            px_q    <= '0;
            py_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            fin_q   <= 1'b0;
          end
        end
        StRun: begin
          if (ren_c) begin
            addr_q <= addr_q + A_WIDTH'(1);
            if (addr_q == LastAddr) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (win_valid_q && win_ready && win_last_q) state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase

      rd_vld_q   <= ren_c;
      skid_vld_q <= skid_vld_d;
      if (rd_vld_q && (skid_vld_q ? advance : !advance)) skid_q <= rdata;

      if (win_valid_q && win_ready) begin
        win_valid_q <= 1'b0;
        win_last_q  <= 1'b0;
      end

      if (advance) begin
        col0_q <= col1_q;
        col1_q <= new_col;
        if (px_q == XMax) begin
          px_q <= '0;
          py_q <= py_q + YW'(1);
        end else begin
          px_q <= px_q + XW'(1);
        end
        if (produce) begin
          win_data_q  <= win_n;
          win_valid_q <= 1'b1;
          win_last_q  <= is_last;
          if (is_last) fin_q <= 1'b1;
          if (cx_q == XMax) begin
            cx_q <= '0;
            cy_q <= cy_q + YW'(1);
          end else begin
            cx_q <= cx_q + XW'(1);
          end
        end
      end
    end
  end

endmodule
